// File: rtl/led_disp_sched.sv
`default_nettype none
// ============================================================================
// Module      : led_disp_sched
// Description : Round-robin display scheduler with minimum dwell and urgent
//               preemption. It shares the 8-LED bank and the seven-segment
//               digit among NUM_REQ requesters.
//               Optional macro LED_SCHED_URGENT_DP_EN: the DP segment is lit
//               while the current grant was won through the urgent path.
// Revision    : 1.0 - initial release
// ============================================================================
module led_disp_sched #(
    parameter int   NUM_REQ      = 4,
    parameter int   DWELL_CYCLES = 125_000_000,
    parameter logic LED_POLARITY = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   urgent_i,
    input  logic [NUM_REQ*8-1:0] led_data_i,
    input  logic [NUM_REQ*8-1:0] seg_data_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [2:0]           owner_o,
    output logic [7:0]           led_display_o,
    output logic [7:0]           seg_display_o
);

    localparam int              CW          = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0]   c_dwell_max = CW'(DWELL_CYCLES - 1);
    localparam logic [7:0]      c_blank     = {8{~LED_POLARITY}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [2:0]           r_owner;
    logic [2:0]           r_last_owner;
    logic [CW-1:0]        r_dwell;
    logic [7:0]           r_led;
    logic [7:0]           r_seg;

    logic [NUM_REQ-1:0]   w_urg;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [2:0]           w_pick;
    logic [2:0]           w_urg_pick;
    logic [2:0]           w_rr_low;
    logic [2:0]           w_rr_high;
    logic                 w_rr_high_found;
    logic                 w_any_req;
    logic                 w_sat;
    logic                 w_own_req;
    logic                 w_own_urg;
    logic                 w_other_req;
    logic                 w_other_urg;
    logic                 w_exit;
    logic                 w_do_grant;
    logic [7:0]           w_led_sel;
    logic [7:0]           w_seg_sel;
    logic [7:0]           w_seg_next;

    assign w_urg       = req_i & urgent_i;
    assign w_any_req   = |req_i;
    assign w_sat       = (r_dwell == c_dwell_max);
    assign w_own_req   = |(req_i & r_gnt);
    assign w_own_urg   = |(urgent_i & r_gnt);
    assign w_other_req = |(req_i & ~r_gnt);
    assign w_other_urg = |(w_urg & ~r_gnt);
    assign w_exit      = !w_own_req || (w_sat && w_other_req) || (w_other_urg && !w_own_urg);

    // Round-robin = lowest requester above last_owner, else lowest overall.
    always_comb begin
        w_urg_pick      = '0;
        w_rr_low        = '0;
        w_rr_high       = '0;
        w_rr_high_found = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_urg[j]) begin
                w_urg_pick = 3'(j);
            end
            if (req_i[j]) begin
                w_rr_low = 3'(j);
            end
            if (req_i[j] && (j > int'(r_last_owner))) begin
                w_rr_high       = 3'(j);
                w_rr_high_found = 1'b1;
            end
        end
        w_pick = w_rr_low;
        if (|w_urg) begin
            w_pick = w_urg_pick;
        end else if (w_rr_high_found) begin
            w_pick = w_rr_high;
        end
    end

    always_comb begin
        w_pick_oh = '0;
        w_led_sel = '0;
        w_seg_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_pick_oh[j] = (w_pick == 3'(j));
            if (r_owner == 3'(j)) begin
                w_led_sel = led_data_i[j*8 +: 8];
                w_seg_sel = seg_data_i[j*8 +: 8];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_do_grant   = 1'b0;
        case (r_state)
            IDLE, HANDOFF: begin
                if (w_any_req) begin
                    w_next_state = OWN;
                    w_do_grant   = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            OWN: begin
                if (w_exit) begin
                    w_next_state = HANDOFF;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef LED_SCHED_URGENT_DP_EN
    logic r_urgent_grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_urgent_grant <= 1'b0;
        end else if (w_do_grant) begin
            r_urgent_grant <= |w_urg;
        end else if (w_next_state != OWN) begin
            r_urgent_grant <= 1'b0;
        end
    end

    always_comb begin
        w_seg_next = w_seg_sel ^ c_blank;
        if (r_urgent_grant) begin
            w_seg_next[7] = LED_POLARITY;
        end
    end
`else
    always_comb begin
        w_seg_next = w_seg_sel ^ c_blank;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= 3'(NUM_REQ - 1);
            r_dwell      <= '0;
            r_led        <= c_blank;
            r_seg        <= c_blank;
        end else begin
            r_state <= w_next_state;
            if (w_do_grant) begin
                r_gnt        <= w_pick_oh;
                r_owner      <= w_pick;
                r_last_owner <= w_pick;
                r_dwell      <= '0;
            end else if (w_next_state != OWN) begin
                r_gnt   <= '0;
                r_dwell <= '0;
            end else if (!w_sat) begin
                r_dwell <= r_dwell + CW'(1);
            end
            // Data shows one cycle after the grant and blanks with it on exit.
            if ((r_state == OWN) && (w_next_state == OWN)) begin
                r_led <= w_led_sel ^ c_blank;
                r_seg <= w_seg_next;
            end else begin
                r_led <= c_blank;
                r_seg <= c_blank;
            end
        end
    end

    assign gnt_o         = r_gnt;
    assign owner_o       = r_owner;
    assign led_display_o = r_led;
    assign seg_display_o = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_led_disp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_disp_sched
// Description : Directed self-checking bench for led_disp_sched (NUM_REQ=4,
//               DWELL_CYCLES=8), with a second inverted-polarity instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_disp_sched;

    localparam int NUM_REQ = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ-1:0]   urg = '0;
    logic [NUM_REQ*8-1:0] led_data;
    logic [NUM_REQ*8-1:0] seg_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [2:0]           owner;
    logic [7:0]           led;
    logic [7:0]           seg;
    logic [NUM_REQ-1:0]   gnt_inv;
    logic [2:0]           owner_inv;
    logic [7:0]           led_inv;
    logic [7:0]           seg_inv;

    logic [7:0] led_tab [NUM_REQ] = '{8'hA5, 8'h5A, 8'h81, 8'h3C};
    logic [7:0] seg_tab [NUM_REQ] = '{8'h06, 8'h5B, 8'h4F, 8'h66};

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            led_data[k*8 +: 8] = led_tab[k];
            seg_data[k*8 +: 8] = seg_tab[k];
        end
    end

    led_disp_sched #(.NUM_REQ(NUM_REQ), .DWELL_CYCLES(8), .LED_POLARITY(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .urgent_i(urg),
        .led_data_i(led_data), .seg_data_i(seg_data),
        .gnt_o(gnt), .owner_o(owner), .led_display_o(led), .seg_display_o(seg)
    );

    led_disp_sched #(.NUM_REQ(NUM_REQ), .DWELL_CYCLES(8), .LED_POLARITY(1'b0)) u_dut_inv (
        .clk_i(clk), .rst_i(rst), .req_i(req), .urgent_i(urg),
        .led_data_i(led_data), .seg_data_i(seg_data),
        .gnt_o(gnt_inv), .owner_o(owner_inv), .led_display_o(led_inv), .seg_display_o(seg_inv)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        logic [3:0] exp_oh;

        // Reset held for three edges
        repeat (3) @(negedge clk);
        check_eq("rst_gnt", gnt, 4'b0000);
        check_eq("rst_owner", owner, 3'd0);
        check_eq("rst_led", led, 8'h00);
        check_eq("rst_seg", seg, 8'h00);
        check_eq("rst_led_inv", led_inv, 8'hFF);
        check_eq("rst_seg_inv", seg_inv, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_gnt", gnt, 4'b0000);

        // Round-robin rotation 0,1,2,3,0 with 8-cycle dwell plus 1 handoff
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            exp_oh = 4'b0001 << (r % 4);
            @(negedge clk);
            check_eq("rr_grant", gnt, exp_oh);
            check_eq("rr_owner", owner, r % 4);
            check_eq("rr_led_blank", led, 8'h00);
            @(negedge clk);
            check_eq("rr_led", led, led_tab[r % 4]);
            check_eq("rr_seg", seg, seg_tab[r % 4]);
            repeat (6) @(negedge clk);
            check_eq("rr_hold_last", gnt, exp_oh);
            @(negedge clk);
            check_eq("rr_handoff_gnt", gnt, 4'b0000);
            check_eq("rr_handoff_led", led, 8'h00);
        end

        // Sole requester keeps the display beyond saturation
        req = 4'b0100;
        @(negedge clk);
        check_eq("sole_grant", gnt, 4'b0100);
        bad = 0;
        repeat (55) begin
            @(negedge clk);
            if (gnt !== 4'b0100) bad++;
        end
        check_eq("sole_hold_glitches", bad, 0);
        check_eq("sole_led", led, 8'h81);
        req = 4'b0000;
        @(negedge clk);
        check_eq("sole_drop_gnt", gnt, 4'b0000);
        check_eq("sole_drop_led", led, 8'h00);
        @(negedge clk);
        check_eq("idle_after_drop", gnt, 4'b0000);

        // Urgent preemption of a non-urgent owner in dwell cycle 2
        req = 4'b0001;
        @(negedge clk);
        check_eq("u_grant0", gnt, 4'b0001);
        repeat (2) @(negedge clk);
        req = 4'b1001;
        urg = 4'b1000;
        @(negedge clk);
        check_eq("u_handoff", gnt, 4'b0000);
        @(negedge clk);
        check_eq("u_grant3", gnt, 4'b1000);
        check_eq("u_owner3", owner, 3'd3);
        @(negedge clk);
        check_eq("u_led3", led, 8'h3C);
`ifdef LED_SCHED_URGENT_DP_EN
        check_eq("u_seg3_dp", seg, 8'hE6);
`else
        check_eq("u_seg3_dp", seg, 8'h66);
`endif
        // Urgent owner is not preempted by another urgent requester
        req = 4'b1011;
        urg = 4'b1010;
        repeat (4) @(negedge clk);
        check_eq("u_no_preempt", gnt, 4'b1000);
        repeat (2) @(negedge clk);
        check_eq("u_hold_last", gnt, 4'b1000);
        @(negedge clk);
        check_eq("u_sat_handoff", gnt, 4'b0000);
        @(negedge clk);
        check_eq("u_grant1", gnt, 4'b0010);

        // Reset mid-grant with requests still pending
        rst = 1'b1;
        req = 4'b0011;
        urg = 4'b0000;
        @(negedge clk);
        check_eq("mid_rst_gnt", gnt, 4'b0000);
        check_eq("mid_rst_led", led, 8'h00);
        check_eq("mid_rst_seg_inv", seg_inv, 8'hFF);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_grant", gnt, 4'b0001);
        check_eq("post_rst_owner", owner, 3'd0);
        @(negedge clk);
        check_eq("normal_seg_dp", seg, 8'h06);
        check_eq("inv_led", led_inv, 8'h5A);
        check_eq("inv_seg", seg_inv, 8'hF9);

        // Owner drop and urgent arrival in the same cycle: one handoff, urgent wins
        req = 4'b0110;
        urg = 4'b0100;
        @(negedge clk);
        check_eq("drop_urg_handoff", gnt, 4'b0000);
        @(negedge clk);
        check_eq("drop_urg_grant", gnt, 4'b0100);
        check_eq("drop_urg_owner", owner, 3'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
